// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI transaction arbiter.
//   arb_state_e : arbiter FSM states
//   TMO_RESP    : response reported for a transaction that timed out
//   A2D_*       : A2D channel command words used by the channel sequencer
package spi_arb_pkg;

    localparam int unsigned CMD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic [CMD_W-1:0] TMO_RESP   = 16'hFFFF;

    localparam logic [CMD_W-1:0] A2D_BATT   = 16'h0000;
    localparam logic [CMD_W-1:0] A2D_CURR   = 16'h0800;
    localparam logic [CMD_W-1:0] A2D_BRAKE  = 16'h1800;
    localparam logic [CMD_W-1:0] A2D_TORQUE = 16'h2000;

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping past the top.
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot winner (zero when no request)
//   vld : at least one request present
module spi_arbiter_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               vld
);

    logic [NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0] gnt_rot;
    logic               found;

    // Rotate so ptr lands at bit 0, pick lowest set bit, rotate back.
    assign req_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        gnt_rot = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                gnt_rot[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign gnt = NUM_REQ'(({gnt_rot, gnt_rot} << ptr) >> NUM_REQ);
    assign vld = |req;

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master transaction engine among
// NUM_REQ requesters, with locked back-to-back sequences and an idle gap
// after every transaction.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction whose
// spi_done has not arrived TIMEOUT clocks after spi_snd.
//   req/lock/cmd       : per-requester request level, lock, command word
//   gnt/rdy            : one-hot owner and end-of-transaction pulse
//   resp_out/err       : last response and timeout flag (valid with rdy)
//   spi_snd/spi_cmd    : start pulse and command to the SPI master
//   spi_done/spi_resp  : completion pulse and response from the SPI master
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 2048
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [CMD_W*NUM_REQ-1:0] cmd,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rdy,
    output logic [CMD_W-1:0]         resp_out,
    output logic                     err,
    output logic                     spi_snd,
    output logic [CMD_W-1:0]         spi_cmd,
    input  logic                     spi_done,
    input  logic [CMD_W-1:0]         spi_resp
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                lock_q, lock_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  rdy_q, rdy_d;
    logic [CMD_W-1:0]    resp_q, resp_d;
    logic [CMD_W-1:0]    cmd_q, cmd_d;
    logic                err_q, err_d;
    logic                snd_q, snd_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic                pick_vld;
    logic [CMD_W-1:0]    pick_cmd;
    logic [CMD_W-1:0]    own_cmd;
    logic [PTR_W-1:0]    own_next;
    logic                own_req;
    logic                own_lock;
    logic                gap_last;
    logic                tmo_ev;
    logic                done_ev;

    spi_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    // Command of the arbitration winner and per-owner views of the inputs.
    always_comb begin
        pick_cmd = '0;
        own_cmd  = '0;
        own_next = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) pick_cmd = cmd[CMD_W*i +: CMD_W];
            if (gnt_q[i]) begin
                own_cmd  = cmd[CMD_W*i +: CMD_W];
                own_next = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign own_req  = |(req & gnt_q);
    assign own_lock = |(lock & gnt_q);
    assign gap_last = (gap_q == GAP_W'(GAP_CYCLES - 1));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;

    // Clocks spent in BUSY; restarted every SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                tmo_q <= '0;
        else if (state_q == SEND)  tmo_q <= '0;
        else if (state_q == BUSY)  tmo_q <= tmo_q + TMO_W'(1);
    end

    // A real spi_done in the same clock wins over the timeout.
    assign tmo_ev = (state_q == BUSY) && !spi_done && (tmo_q == TMO_W'(TIMEOUT - 1));
`else
    assign tmo_ev = 1'b0;
`endif

    assign done_ev = (state_q == BUSY) && (spi_done || tmo_ev);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_vld) state_d = SEND;
            SEND: state_d = BUSY;
            BUSY: if (done_ev) state_d = GAP;
            GAP:  if (gap_last) state_d = (lock_q && own_req) ? SEND : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_d  = gnt_q;
        rdy_d  = '0;
        resp_d = resp_q;
        err_d  = err_q;
        cmd_d  = cmd_q;
        ptr_d  = ptr_q;
        gap_d  = gap_q;
        lock_d = lock_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d = pick_gnt;
                    cmd_d = pick_cmd;
                end
            end
            BUSY: begin
                if (done_ev) begin
                    resp_d = tmo_ev ? TMO_RESP : spi_resp;
                    rdy_d  = gnt_q;
                    err_d  = tmo_ev;
                    lock_d = own_lock && !tmo_ev;
                    gap_d  = '0;
                end
            end
            GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_last) begin
                    if (lock_q && own_req) begin
                        cmd_d = own_cmd;
                    end else begin
                        gnt_d = '0;
                        ptr_d = own_next;
                    end
                end
            end
            default: ;
        endcase
        snd_d = (state_d == SEND);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            rdy_q  <= '0;
            resp_q <= '0;
            err_q  <= 1'b0;
            cmd_q  <= '0;
            snd_q  <= 1'b0;
            ptr_q  <= '0;
            gap_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            rdy_q  <= rdy_d;
            resp_q <= resp_d;
            err_q  <= err_d;
            cmd_q  <= cmd_d;
            snd_q  <= snd_d;
            ptr_q  <= ptr_d;
            gap_q  <= gap_d;
            lock_q <= lock_d;
        end
    end

    assign gnt      = gnt_q;
    assign rdy      = rdy_q;
    assign resp_out = resp_q;
    assign err      = err_q;
    assign spi_snd  = snd_q;
    assign spi_cmd  = cmd_q;

endmodule
